// File: rtl/opload_pkg.sv
// Shared definitions for the operand-entry stage: FSM state encodings
// (identical to the LED state output) and the default debounce length.
package opload_pkg;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    ISSUE  = 2'b10,
    DONE   = 2'b11
  } state_t;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces an active-low push-button, emitting a
// one-cycle press pulse when the debounced level falls.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level held for DEBOUNCE_CYCLES samples; only a fall is an event.
        stable <= s2;
        cnt    <= '0;
        press  <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Operand-entry stage: two key presses capture A, then B and the
// add/subtract select, which are then offered to the adder.
module operand_loader
  import opload_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             sw_op,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_sel,
  output logic             op_valid,
  output logic [1:0]       state
);

  // Handshake: a transfer happens on the rising edge where op_valid and
  // op_ready are both high; op_valid and the operands stay fixed until then.

  logic             press;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sel_q, sel_d;
  logic             valid_q;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .key_n  (key_n),
    .press  (press)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      valid_q <= (state_d == ISSUE);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    case (state_q)
      WAIT_A: begin
        if (press) begin
          a_d     = sw_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press) begin
          b_d     = sw_data;
          sel_d   = sw_op;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Presses here are intentionally dropped.
        if (valid_q && op_ready) state_d = DONE;
      end
      DONE: begin
        if (press) begin
          a_d     = sw_data;
          state_d = WAIT_B;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_sel   = sel_q;
  assign op_valid = valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce; transfers are
// scored against an expected queue of {op_sel, op_b, op_a}.
module tb_operand_loader;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         resetn;
  logic         key_n;
  logic [W-1:0] sw_data;
  logic         sw_op;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sel;
  logic         op_valid;
  logic [1:0]   state;

  logic [2*W:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  operand_loader #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .key_n    (key_n),
    .sw_data  (sw_data),
    .sw_op    (sw_op),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sel   (op_sel),
    .op_valid (op_valid),
    .state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the key low through E5; the capture edge is the caller's next tick.
  task automatic press_key(input logic [W-1:0] data, input logic sel);
    sw_data = data;
    sw_op   = sel;
    key_n   = 1'b0;
    repeat (6) tick();
  endtask

  task automatic release_key();
    key_n   = 1'b1;
    sw_data = W'($urandom_range(0, 15));
    sw_op   = 1'($urandom_range(0, 1));
    repeat (8) tick();
  endtask

  task automatic chk_outputs(input string tag, input logic [1:0] st, input logic v,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    chk({tag, "_state"}, 8'(state), 8'(st));
    chk({tag, "_valid"}, 8'(op_valid), 8'(v));
    chk({tag, "_op_a"}, 8'(op_a), 8'(a));
    chk({tag, "_op_b"}, 8'(op_b), 8'(b));
    chk({tag, "_op_sel"}, 8'(op_sel), 8'(s));
  endtask

  // scoreboard: every accepted transfer must match the oldest expectation
  always @(negedge clk) begin
    if (resetn && op_valid && op_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL xfer_unexpected observed %0h expected none", {op_sel, op_b, op_a});
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        assert ({op_sel, op_b, op_a} === e) else begin
          errors++;
          $error("FAIL xfer_data observed %0h expected %0h", {op_sel, op_b, op_a}, e);
        end
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    key_n    = 1'b1;
    sw_data  = '0;
    sw_op    = 1'b0;
    op_ready = 1'b1;

    // reset with key toggling
    tick();                chk_outputs("rst0", 2'b00, 0, 0, 0, 0);
    key_n = 1'b0; tick();  chk_outputs("rst1", 2'b00, 0, 0, 0, 0);
    key_n = 1'b1;
    resetn = 1'b1; tick(); chk_outputs("rst2", 2'b00, 0, 0, 0, 0);
    repeat (6) tick();     chk_outputs("rst3", 2'b00, 0, 0, 0, 0);

    // operand A: captured exactly at E6
    press_key(4'h5, 1'b0);
    chk_outputs("a5_pre", 2'b00, 0, 4'h0, 0, 0);
    tick();
    chk_outputs("a5", 2'b01, 0, 4'h5, 0, 0);
    release_key();
    chk_outputs("a5_hold", 2'b01, 0, 4'h5, 0, 0);

    // operand B with ready already high: ISSUE lasts one cycle
    exp_q.push_back({1'b1, 4'h3, 4'h5});
    press_key(4'h3, 1'b1);
    tick();
    chk_outputs("b3", 2'b10, 1, 4'h5, 4'h3, 1);
    tick();
    chk_outputs("b3_done", 2'b11, 0, 4'h5, 4'h3, 1);
    release_key();
    chk_outputs("done_hold", 2'b11, 0, 4'h5, 4'h3, 1);

    // backpressure, with an ignored press while in ISSUE
    press_key(4'h7, 1'b0);
    tick();
    chk_outputs("a7", 2'b01, 0, 4'h7, 4'h3, 1);
    release_key();
    op_ready = 1'b0;
    exp_q.push_back({1'b1, 4'h2, 4'h7});
    press_key(4'h2, 1'b1);
    tick();
    chk_outputs("bp_enter", 2'b10, 1, 4'h7, 4'h2, 1);
    key_n = 1'b1;
    sw_data = 4'hC;
    sw_op = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_outputs("bp_hold", 2'b10, 1, 4'h7, 4'h2, 1);
    end
    key_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_outputs("bp_press", 2'b10, 1, 4'h7, 4'h2, 1);
    end
    op_ready = 1'b1;
    tick();
    chk_outputs("bp_done", 2'b11, 0, 4'h7, 4'h2, 1);
    release_key();
    chk("bp_drained", 8'(exp_q.size()), 8'd0);

    // bounce shorter than D samples
    key_n = 1'b0; repeat (3) tick();
    key_n = 1'b1; tick();
    key_n = 1'b0; repeat (3) tick();
    key_n = 1'b1; repeat (10) tick();
    chk_outputs("bounce", 2'b11, 0, 4'h7, 4'h2, 1);

    // re-entry from DONE keeps old B and select
    press_key(4'hF, 1'b0);
    tick();
    chk_outputs("reentry", 2'b01, 0, 4'hF, 4'h2, 1);
    release_key();

    // reset in WAIT_B after op_a = 9
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    press_key(4'h9, 1'b0);
    tick();
    chk_outputs("a9", 2'b01, 0, 4'h9, 0, 0);
    release_key();
    resetn = 1'b0;
    tick();
    chk_outputs("rst_waitb", 2'b00, 0, 0, 0, 0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_outputs("rst_waitb_after", 2'b00, 0, 0, 0, 0);
    end

    // reset in ISSUE with op_valid high: no transfer
    op_ready = 1'b0;
    press_key(4'h6, 1'b0); tick(); release_key();
    press_key(4'h1, 1'b1); tick();
    chk_outputs("issue_pre_rst", 2'b10, 1, 4'h6, 4'h1, 1);
    resetn = 1'b0;
    key_n  = 1'b1;
    tick();
    chk_outputs("rst_issue", 2'b00, 0, 0, 0, 0);
    resetn   = 1'b1;
    op_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_outputs("rst_issue_after", 2'b00, 0, 0, 0, 0);
    end

    chk("queue_empty", 8'(exp_q.size()), 8'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
